// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the iterative AES-128 encryption core.
//   NR        number of AES-128 rounds
//   block_t   128-bit state / key, byte 0 in bits [127:120]
//   word_t    32-bit key-schedule word
//   aes_fsm_t controller states
//   RCON      round constants, indexed 1..10
//   sbox()    forward S-box lookup
//   xtime()   multiply by x in GF(2^8)
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_fsm_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX_TBL [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: round key k_(r-1) -> k_r.
//   prev_key  previous round key
//   rnd       round index r (1..10); other values use a zero round constant
//   next_key  round key for round r
module aes_key_step
  import aes_pkg::*;
(
  input  block_t     prev_key,
  input  logic [3:0] rnd,
  output block_t     next_key
);

  word_t w0, w1, w2, w3, t;
  word_t n0, n1, n2, n3;
  logic [7:0] rc;

  assign {w0, w1, w2, w3} = prev_key;

  // out-of-range indices only occur while the datapath output is not captured
  assign rc = (rnd >= 4'd1 && rnd <= 4'd10) ? RCON[rnd] : 8'h00;

  // RotWord then SubWord on the last word, then Rcon into its leading byte
  assign t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// MixColumns: each 4-byte column multiplied by the fixed polynomial {03}x^3+{01}x^2+{01}x+{02}.
//   din   state in
//   dout  state out
module mix_columns
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[127-32*c -: 8];
    assign a1 = din[119-32*c -: 8];
    assign a2 = din[111-32*c -: 8];
    assign a3 = din[103-32*c -: 8];
    assign dout[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign dout[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign dout[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign dout[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r of the column-major state is rotated left by r bytes.
//   din   state in
//   dout  state out
module shift_rows
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout
);

  // byte index within the block is 4*column + row
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: S-box applied to each of the 16 state bytes.
//   din   state in
//   dout  state out
module sub_bytes
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core, UNROLL rounds per clock, on-the-fly key schedule.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_pt, in_key, in_tag sampled on accept
//   out_valid/out_ready  output handshake; out_ct, out_tag held until consumed
//   busy                 a block is in RUN or waiting in DONE
//
// state | meaning
// IDLE  | empty, waiting for an input block
// RUN   | computing UNROLL rounds per cycle, ITER cycles in total
// DONE  | ciphertext presented, held until out_ready
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_pt,
  input  logic [127:0]     in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_ct,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int ITER = NR / UNROLL;
  localparam int CW   = $clog2(ITER + 1);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_enc_iter: UNROLL must be 1, 2, 5 or 10");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_enc_iter: TAG_W must be at least 1");
  end

  aes_fsm_t         fsm;
  block_t           state_q;
  block_t           rk_q;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;

  block_t st [0:UNROLL];
  block_t kk [0:UNROLL];

  assign st[0] = state_q;
  assign kk[0] = rk_q;

  // The stage that lands on round 10 depends on cnt, so the MixColumns bypass
  // is a runtime select in every stage rather than a fixed last-stage tweak.
  for (genvar j = 0; j < UNROLL; j++) begin : g_stage
    block_t     sb, sr, mc;
    logic [3:0] rnd;

    assign rnd = 4'(int'(cnt) * UNROLL + j + 1);

    sub_bytes    u_sb (.din(st[j]), .dout(sb));
    shift_rows   u_sr (.din(sb),    .dout(sr));
    mix_columns  u_mc (.din(sr),    .dout(mc));
    aes_key_step u_ks (.prev_key(kk[j]), .rnd(rnd), .next_key(kk[j+1]));

    assign st[j+1] = ((rnd == 4'd10) ? sr : mc) ^ kk[j+1];
  end

  assign in_ready = (fsm == IDLE) || (fsm == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_ct   = state_q;
  assign out_tag  = tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      state_q   <= '0;
      rk_q      <= '0;
      cnt       <= '0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // covers both the IDLE load and the back-to-back load out of DONE
      fsm       <= RUN;
      state_q   <= in_pt ^ in_key;
      rk_q      <= in_key;
      tag_q     <= in_tag;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (fsm)
        RUN: begin
          state_q <= st[UNROLL];
          rk_q    <= kk[UNROLL];
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
`timescale 1ns/1ps
module tb_aes_enc_iter;

  localparam int ND = 4;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst;
  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic [127:0] in_pt     [ND];
  logic [127:0] in_key    [ND];
  logic [7:0]   in_tag    [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic [127:0] out_ct    [ND];
  logic [7:0]   out_tag   [ND];
  logic         busy      [ND];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int UN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes_enc_iter #(.UNROLL(UN), .TAG_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_pt     (in_pt[g]),
      .in_key    (in_key[g]),
      .in_tag    (in_tag[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_ct    (out_ct[g]),
      .out_tag   (out_tag[g]),
      .busy      (busy[g])
    );
  end

  function automatic int unr(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 5 : 10;
  endfunction

  function automatic int iter(input int d);
    return 10 / unr(d);
  endfunction

  // ---------------- reference model: textbook AES-128 on byte arrays ----------------
  logic [7:0] sb_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a, p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s = inv;
      for (int k = 1; k <= 4; k++) begin
        b = {b[6:0], b[7]};
        s = s ^ b;
      end
      sb_tab[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [176];
    logic [7:0] tmp [4];
    logic [7:0] rc, x;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int k = 0; k < 4; k++) tmp[k] = w[4*(i-1)+k];
      if (i % 4 == 0) begin
        x = tmp[0];
        tmp[0] = sb_tab[tmp[1]] ^ rc;
        tmp[1] = sb_tab[tmp[2]];
        tmp[2] = sb_tab[tmp[3]];
        tmp[3] = sb_tab[x];
        rc = gmul(rc, 8'h02);
      end
      for (int k = 0; k < 4; k++) w[4*i+k] = w[4*(i-4)+k] ^ tmp[k];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = s[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (unroll=%0d): got %h, expected %h", nm, unr(d), act, exp);
    end
  endtask

  // Present a block, wait (bounded) for in_ready, return just after the accept edge.
  task automatic start_block(input int d, input logic [127:0] key, input logic [127:0] pt,
                             input logic [7:0] tag);
    int n;
    in_key[d]   = key;
    in_pt[d]    = pt;
    in_tag[d]   = tag;
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_before_accept", d, in_ready[d], 1);
    step();
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_check(input int d, input logic [127:0] key, input logic [127:0] pt,
                           input logic [7:0] tag, input logic [127:0] exp);
    int lat;
    start_block(d, key, pt, tag);
    wait_out(d, lat);
    chk("latency", d, lat, iter(d));
    chk("out_valid", d, out_valid[d], 1);
    chk("out_ct", d, out_ct[d], exp);
    chk("out_tag", d, out_tag[d], tag);
    step();
    chk("consumed_out_valid", d, out_valid[d], 0);
    chk("consumed_busy", d, busy[d], 0);
    chk("consumed_in_ready", d, in_ready[d], 1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [7:0]   tag;
    logic [127:0] ct;
  } vec_t;

  vec_t vt [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [127:0] k, p;
    logic [7:0] tg;

    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      in_pt[d]     = '0;
      in_key[d]    = '0;
      in_tag[d]    = '0;
    end

    vt[0] = '{C1_KEY, C1_PT, 8'h5A, C1_CT};
    vt[1] = '{B_KEY,  B_PT,  8'hC3, B_CT};
    vt[2] = '{128'h0, 128'h0, 8'h01, Z_CT};

    build_sbox();
    chk("model_c1", 0, aes_ref(C1_KEY, C1_PT), C1_CT);
    chk("model_b", 0, aes_ref(B_KEY, B_PT), B_CT);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_out_valid", d, out_valid[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_out_ct", d, out_ct[d], 0);
      chk("rst_out_tag", d, out_tag[d], 0);
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < ND; d++) chk("rst_in_ready", d, in_ready[d], 1);

    // known-answer table on every unroll factor
    for (int d = 0; d < ND; d++)
      for (int v = 0; v < 3; v++)
        run_check(d, vt[v].key, vt[v].pt, vt[v].tag, vt[v].ct);

    // random blocks against the model
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 6; i++) begin
        k  = {$urandom, $urandom, $urandom, $urandom};
        p  = {$urandom, $urandom, $urandom, $urandom};
        tg = 8'($urandom_range(0, 255));
        run_check(d, k, p, tg, aes_ref(k, p));
      end

    // back-pressure: hold DONE for 7 cycles, with an input offered meanwhile
    for (int d = 0; d < ND; d += 3) begin
      out_ready[d] = 1'b0;
      start_block(d, C1_KEY, C1_PT, 8'h77);
      wait_out(d, lat);
      chk("bp_latency", d, lat, iter(d));
      for (int i = 0; i < 7; i++) begin
        if (i == 2) begin
          in_valid[d] = 1'b1;
          in_key[d]   = {$urandom, $urandom, $urandom, $urandom};
          in_pt[d]    = {$urandom, $urandom, $urandom, $urandom};
          in_tag[d]   = 8'hEE;
        end
        step();
        chk("bp_out_valid", d, out_valid[d], 1);
        chk("bp_out_ct", d, out_ct[d], C1_CT);
        chk("bp_out_tag", d, out_tag[d], 8'h77);
        chk("bp_in_ready", d, in_ready[d], 0);
        chk("bp_busy", d, busy[d], 1);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      step();
      chk("bp_release_out_valid", d, out_valid[d], 0);
      chk("bp_release_busy", d, busy[d], 0);
      chk("bp_release_in_ready", d, in_ready[d], 1);
    end

    // back-to-back: 4 blocks, alternating keys, no bubble between them
    for (int d = 0; d < ND; d++) begin
      start_block(d, C1_KEY, C1_PT, 8'h10);
      for (int b = 0; b < 4; b++) begin
        wait_out(d, lat);
        chk("b2b_period", d, lat, iter(d));
        chk("b2b_out_ct", d, out_ct[d], (b % 2 == 0) ? C1_CT : B_CT);
        chk("b2b_out_tag", d, out_tag[d], 8'(8'h10 + b));
        if (b < 3) begin
          in_valid[d] = 1'b1;
          in_key[d]   = (b % 2 == 0) ? B_KEY : C1_KEY;
          in_pt[d]    = (b % 2 == 0) ? B_PT : C1_PT;
          in_tag[d]   = 8'(8'h10 + b + 1);
          chk("b2b_in_ready", d, in_ready[d], 1);
        end
        step();
        in_valid[d] = 1'b0;
        if (b < 3) begin
          chk("b2b_reload_busy", d, busy[d], 1);
          chk("b2b_reload_out_valid", d, out_valid[d], 0);
        end
      end
      chk("b2b_end_busy", d, busy[d], 0);
    end

    // garbage on in_valid while RUN is ignored
    for (int d = 0; d < 2; d++) begin
      start_block(d, C1_KEY, C1_PT, 8'h3C);
      step();
      in_valid[d] = 1'b1;
      in_key[d]   = {$urandom, $urandom, $urandom, $urandom};
      in_pt[d]    = {$urandom, $urandom, $urandom, $urandom};
      in_tag[d]   = 8'hBD;
      chk("run_in_ready", d, in_ready[d], 0);
      step();
      step();
      in_valid[d] = 1'b0;
      wait_out(d, lat);
      chk("ign_out_ct", d, out_ct[d], C1_CT);
      chk("ign_out_tag", d, out_tag[d], 8'h3C);
      step();
    end

    // async reset mid-RUN (cycle 4 of 10)
    start_block(0, C1_KEY, C1_PT, 8'h99);
    step();
    step();
    step();
    chk("pre_rst_busy", 0, busy[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_run_out_valid", 0, out_valid[0], 0);
    chk("rst_run_busy", 0, busy[0], 0);
    chk("rst_run_out_tag", 0, out_tag[0], 0);
    step();
    rst = 1'b0;
    step();
    chk("rst_run_in_ready", 0, in_ready[0], 1);
    chk("rst_run_busy_after", 0, busy[0], 0);
    run_check(0, C1_KEY, C1_PT, 8'h5A, C1_CT);

    // async reset while DONE: out_valid must drop without a clock edge
    out_ready[2] = 1'b0;
    start_block(2, B_KEY, B_PT, 8'h42);
    wait_out(2, lat);
    chk("rst_done_pre_valid", 2, out_valid[2], 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_done_out_valid", 2, out_valid[2], 0);
    chk("rst_done_out_ct", 2, out_ct[2], 0);
    step();
    rst = 1'b0;
    out_ready[2] = 1'b1;
    step();
    chk("rst_done_in_ready", 2, in_ready[2], 1);
    run_check(2, C1_KEY, C1_PT, 8'h5A, C1_CT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
